// File: rtl/rf_wb_ctrl.sv
// Register-file write-port controller: merges ALU (port A) and buffered load/muldiv (port B)
// writebacks onto one registered write port and tracks pending destinations. Optional: RF_BYPASS_EN.
module rf_wb_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        issue_valid,
    input  logic [4:0]  issue_dest,
    output logic        issue_ready,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic        hazard1,
    output logic        hazard2,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
`ifdef RF_BYPASS_EN
    ,
    output logic        fwd1,
    output logic        fwd2,
    output logic [31:0] fwd_data
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    logic [4:0]    fifo_addr [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [SW-1:0] starve_cnt;
    logic [31:0]   pend;
    logic [31:0]   pend_nxt;

    logic        empty, full, push, pop, force_b, a_win, win;
    logic [4:0]  win_addr;
    logic [31:0] win_data;
    logic        clr_en;
    logic [4:0]  clr_addr;
    logic        set_en;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign b_ready = !full;
    assign push    = b_valid && !full;

    assign force_b = !empty && (starve_cnt == STARVE_C);
    assign a_ready = !force_b;
    assign a_win   = a_valid && !force_b;
    assign pop     = !empty && !a_win;
    assign win     = a_win || pop;

    always_comb begin
        win_addr = fifo_addr[rd_ptr];
        win_data = fifo_data[rd_ptr];
        if (a_win) begin
            win_addr = a_addr;
            win_data = a_data;
        end
    end

    assign hazard1     = (raddr1 != '0) && pend[raddr1];
    assign hazard2     = (raddr2 != '0) && pend[raddr2];
    assign issue_ready = (issue_dest == '0) || !pend[issue_dest];
    assign set_en      = issue_valid && issue_ready && (issue_dest != '0);

`ifdef RF_BYPASS_EN
    // Forwarding lets the pending bit drop as soon as the winner is accepted.
    assign clr_en   = win;
    assign clr_addr = win_addr;
    assign fwd1     = rf_we && (rf_waddr == raddr1) && (raddr1 != '0);
    assign fwd2     = rf_we && (rf_waddr == raddr2) && (raddr2 != '0);
    assign fwd_data = rf_wdata;
`else
    assign clr_en   = rf_we;
    assign clr_addr = rf_waddr;
`endif

    // Set is applied after clear so a new producer wins a same-edge collision.
    always_comb begin
        pend_nxt = pend;
        if (clr_en)
            pend_nxt[clr_addr] = 1'b0;
        if (set_en)
            pend_nxt[issue_dest] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= b_addr;
            fifo_data[wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            pend       <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            pend <= pend_nxt;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW + 1)'(1);
            else if (pop && !push)
                count <= count - (AW + 1)'(1);

            if (pop)
                starve_cnt <= '0;
            else if (!empty && a_win)
                starve_cnt <= starve_cnt + SW'(1);

            if (win) begin
                rf_we    <= (win_addr != '0);
                rf_waddr <= win_addr;
                rf_wdata <= win_data;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed self-checking bench for rf_wb_ctrl (default build; RF_BYPASS_EN variants guarded).
module tb_rf_wb_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        issue_ready;
    logic [4:0]  raddr1, raddr2;
    logic        hazard1, hazard2;
    logic        a_valid, a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid, b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef RF_BYPASS_EN
    logic        fwd1, fwd2;
    logic [31:0] fwd_data;
`endif

    int n_cmp = 0;
    int n_err = 0;

    rf_wb_ctrl #(.FIFO_DEPTH(4), .STARVE_MAX(3)) dut (
        .clk(clk), .resetn(resetn),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready),
        .raddr1(raddr1), .raddr2(raddr2), .hazard1(hazard1), .hazard2(hazard2),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef RF_BYPASS_EN
        , .fwd1(fwd1), .fwd2(fwd2), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        resetn = 1'b0;
        issue_valid = 0; issue_dest = 0; raddr1 = 0; raddr2 = 0;
        a_valid = 0; a_addr = 0; a_data = 0; b_valid = 0; b_addr = 0; b_data = 0;
        tick(); tick();
        n_cmp++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            n_err++; $display("FAIL reset_outputs: got we=%b addr=%0d data=%h expected 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        n_cmp++;
        if (b_ready !== 1'b1 || a_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got b_ready=%b a_ready=%b expected 1/1", b_ready, a_ready);
        end
        resetn = 1'b1;
        tick();
        // r3 issued and written by A, one B entry queued, then reset mid-write
        issue_valid = 1; issue_dest = 3;
        a_valid = 1; a_addr = 3; a_data = 32'h0000_0033;
        b_valid = 1; b_addr = 6; b_data = 32'h0000_0066;
        tick();
        issue_valid = 0; a_valid = 0; b_valid = 0; raddr1 = 3;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin
            n_err++; $display("FAIL pre_reset_write: got we=%b addr=%0d expected 1/3", rf_we, rf_waddr);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            n_err++; $display("FAIL reset_midwrite: got we=%b addr=%0d data=%h expected 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        n_cmp++;
        if (hazard1 !== 1'b0 || b_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_hazard: got hazard1=%b b_ready=%b expected 0/1", hazard1, b_ready);
        end
        bad = 0;
        for (int d = 0; d < 32; d++) begin
            issue_dest = 5'(d);
            #1;
            if (issue_ready !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL reset_issue_ready: got %0d dests not ready expected 0", bad);
        end
        tick();
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_err++; $display("FAIL reset_fifo_flush: got rf_we=%b expected 0", rf_we);
        end
        resetn = 1'b1;
        issue_dest = 0; raddr1 = 0;
        tick();
    endtask

    task automatic test_raw();
        issue_valid = 1; issue_dest = 5;
        tick();
        issue_valid = 0; raddr1 = 5;
        #1;
        n_cmp++;
        if (hazard1 !== 1'b1) begin
            n_err++; $display("FAIL raw_pending: got hazard1=%b expected 1", hazard1);
        end
        a_valid = 1; a_addr = 5; a_data = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (hazard1 !== 1'b1 || a_ready !== 1'b1) begin
            n_err++; $display("FAIL raw_cycleN: got hazard1=%b a_ready=%b expected 1/1", hazard1, a_ready);
        end
        tick();
        a_valid = 0;
        #1;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL raw_write: got we=%b addr=%0d data=%h expected 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
`ifdef RF_BYPASS_EN
        n_cmp++;
        if (hazard1 !== 1'b0 || fwd1 !== 1'b1 || fwd_data !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL raw_bypass: got hazard1=%b fwd1=%b fwd_data=%h expected 0/1/deadbeef", hazard1, fwd1, fwd_data);
        end
`else
        n_cmp++;
        if (hazard1 !== 1'b1) begin
            n_err++; $display("FAIL raw_cycleN1: got hazard1=%b expected 1", hazard1);
        end
`endif
        tick();
        n_cmp++;
        if (hazard1 !== 1'b0 || rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL raw_cycleN2: got hazard1=%b we=%b addr=%0d data=%h expected 0/0/5/deadbeef",
                              hazard1, rf_we, rf_waddr, rf_wdata);
        end
        raddr1 = 0;
    endtask

    task automatic test_waw();
        int bad;
        issue_valid = 1; issue_dest = 7;
        tick();
        #1;
        n_cmp++;
        if (issue_ready !== 1'b0) begin
            n_err++; $display("FAIL waw_second_issue: got issue_ready=%b expected 0", issue_ready);
        end
        tick();
        n_cmp++;
        if (issue_ready !== 1'b0) begin
            n_err++; $display("FAIL waw_hold: got issue_ready=%b expected 0", issue_ready);
        end
        issue_valid = 0;
        a_valid = 1; a_addr = 7; a_data = 32'h0000_0077;
        tick();
        a_valid = 0;
        #1;
`ifdef RF_BYPASS_EN
        n_cmp++;
        if (issue_ready !== 1'b1) begin
            n_err++; $display("FAIL waw_N1: got issue_ready=%b expected 1", issue_ready);
        end
`else
        n_cmp++;
        if (issue_ready !== 1'b0) begin
            n_err++; $display("FAIL waw_N1: got issue_ready=%b expected 0", issue_ready);
        end
`endif
        tick();
        n_cmp++;
        if (issue_ready !== 1'b1) begin
            n_err++; $display("FAIL waw_cleared: got issue_ready=%b expected 1", issue_ready);
        end
        issue_valid = 1; issue_dest = 0;
        #1;
        n_cmp++;
        if (issue_ready !== 1'b1) begin
            n_err++; $display("FAIL waw_r0_ready: got issue_ready=%b expected 1", issue_ready);
        end
        tick();
        issue_valid = 0;
        bad = 0;
        for (int d = 0; d < 32; d++) begin
            issue_dest = 5'(d);
            #1;
            if (issue_ready !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL waw_r0_no_pend: got %0d dests not ready expected 0", bad);
        end
        issue_dest = 0;
    endtask

    task automatic test_fifo_full();
        logic        exp_ar, exp_br;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        a_valid = 1; a_addr = 10; a_data = 32'h0000_A0A0;
        for (int c = 0; c < 18; c++) begin
            b_valid = (c < 4);
            b_addr  = 5'(c + 1);
            b_data  = 32'hB000_0000 + 32'(c + 1);
            #1;
            exp_ar = !(c == 4 || c == 8 || c == 12 || c == 16);
            exp_br = (c != 4);
            n_cmp++;
            if (a_ready !== exp_ar || b_ready !== exp_br) begin
                n_err++; $display("FAIL fifo_ready c=%0d: got a_ready=%b b_ready=%b expected %b/%b", c, a_ready, b_ready, exp_ar, exp_br);
            end
            if (c >= 1) begin
                if (c >= 5 && ((c - 1) % 4) == 0) begin
                    exp_addr = 5'((c - 1) / 4);
                    exp_data = 32'hB000_0000 + 32'((c - 1) / 4);
                end else begin
                    exp_addr = 5'd10;
                    exp_data = 32'h0000_A0A0;
                end
                n_cmp++;
                if (rf_we !== 1'b1 || rf_waddr !== exp_addr || rf_wdata !== exp_data) begin
                    n_err++; $display("FAIL fifo_write c=%0d: got we=%b addr=%0d data=%h expected 1/%0d/%h",
                                      c, rf_we, rf_waddr, rf_wdata, exp_addr, exp_data);
                end
            end
            tick();
        end
        a_valid = 0; b_valid = 0;
        tick(); tick();
    endtask

    task automatic test_collision();
        a_valid = 1; a_addr = 9; a_data = 32'h0000_0099;
`ifdef RF_BYPASS_EN
        issue_valid = 1; issue_dest = 9;
        #1;
        n_cmp++;
        if (issue_ready !== 1'b1) begin
            n_err++; $display("FAIL collide_issue: got issue_ready=%b expected 1", issue_ready);
        end
        tick();
        a_valid = 0; issue_valid = 0;
`else
        tick();
        a_valid = 0;
        issue_valid = 1; issue_dest = 9;
        #1;
        n_cmp++;
        if (issue_ready !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd9) begin
            n_err++; $display("FAIL collide_issue: got issue_ready=%b we=%b addr=%0d expected 1/1/9", issue_ready, rf_we, rf_waddr);
        end
        tick();
        issue_valid = 0;
`endif
        raddr1 = 9; raddr2 = 9;
        #1;
        n_cmp++;
        if (hazard1 !== 1'b1 || hazard2 !== 1'b1 || issue_ready !== 1'b0) begin
            n_err++; $display("FAIL collide_set_wins: got hazard1=%b hazard2=%b issue_ready=%b expected 1/1/0",
                              hazard1, hazard2, issue_ready);
        end
        a_valid = 1;
        tick();
        a_valid = 0;
        tick(); tick();
        n_cmp++;
        if (hazard1 !== 1'b0) begin
            n_err++; $display("FAIL collide_cleanup: got hazard1=%b expected 0", hazard1);
        end
        raddr1 = 0; raddr2 = 0; issue_dest = 0;
    endtask

    task automatic test_r0_write();
        int bad;
        issue_valid = 1; issue_dest = 12;
        tick();
        issue_valid = 0; raddr2 = 12;
        a_valid = 1; a_addr = 0; a_data = 32'h0000_1234;
        #1;
        n_cmp++;
        if (a_ready !== 1'b1) begin
            n_err++; $display("FAIL r0_a_ready: got a_ready=%b expected 1", a_ready);
        end
        tick();
        a_valid = 0;
        #1;
        n_cmp++;
        if (rf_we !== 1'b0 || hazard2 !== 1'b1) begin
            n_err++; $display("FAIL r0_no_write: got we=%b hazard2=%b expected 0/1", rf_we, hazard2);
        end
        bad = 0;
        for (int d = 0; d < 32; d++) begin
            issue_dest = 5'(d);
            #1;
            if (issue_ready !== ((d == 12) ? 1'b0 : 1'b1)) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL r0_scoreboard: got %0d wrong dests expected 0", bad);
        end
        a_valid = 1; a_addr = 12;
        tick();
        a_valid = 0;
        tick(); tick();
        n_cmp++;
        if (hazard2 !== 1'b0) begin
            n_err++; $display("FAIL r0_cleanup: got hazard2=%b expected 0", hazard2);
        end
        raddr2 = 0; issue_dest = 0;
    endtask

    initial begin
        test_reset();
        test_raw();
        test_waw();
        test_fifo_full();
        test_collision();
        test_r0_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wb_ctrl.md
Name: rf_wb_ctrl

Overview:
Writer-side controller for the 32x32 register file's single write port. It merges two writeback sources onto one registered write port:
- Port A: the fast ALU path.
- Port B: the load and mul/div path, buffered in a small FIFO.
It also keeps a per-register pending scoreboard, which decode uses to detect RAW and WAW hazards on both read ports. It sits between the EX/MEM writeback paths and the register file, and feeds decode's stall logic.

Parameters:
FIFO_DEPTH, 4, number of entries in the port-B buffer (power of 2, at least 2)
STARVE_MAX, 3, consecutive cycles port B may lose arbitration before it is forced to win

Ports:
clk  input  1  clock; all state updates on the rising edge
resetn  input  1  asynchronous, active-low reset
issue_valid  input  1  decode issues an instruction that writes issue_dest
issue_dest  input  5  destination register of the issuing instruction
issue_ready  output  1  low means WAW stall: issue_dest is already pending
raddr1  input  5  decode read address 1 (the same value presented to the register file)
raddr2  input  5  decode read address 2
hazard1  output  1  raddr1 has a pending write
hazard2  output  1  raddr2 has a pending write
a_valid  input  1  port A writeback request
a_ready  output  1  port A accepted this cycle
a_addr  input  5  port A destination register
a_data  input  32  port A write data
b_valid  input  1  port B push request
b_ready  output  1  port-B FIFO not full
b_addr  input  5  port B destination register
b_data  input  32  port B write data
rf_we  output  1  register file write enable (registered)
rf_waddr  output  5  register file write address (registered)
rf_wdata  output  32  register file write data (registered)

Behaviour:
- Reset (resetn low, asynchronous):
  - Outputs go to rf_we=0, rf_waddr=0, rf_wdata=0.
  - Scoreboard is cleared, FIFO is emptied, starvation counter goes to 0.
  - Reset during an in-flight write discards that write.
- Scoreboard is pend[31:1]; r0 is never pending.
  - hazardN = (raddrN != 0) && pend[raddrN]. This is combinational.
  - issue_ready = (issue_dest == 0) || !pend[issue_dest].
  - On issue_valid && issue_ready && issue_dest != 0, set pend[issue_dest].
- Port-B FIFO:
  - b_ready = !full. A push occurs on b_valid && b_ready.
  - There is no same-cycle pass-through. A pushed entry is selectable from the next cycle at the earliest.
  - Because b_ready is low when full, push-when-full cannot happen. Push and pop in the same cycle are allowed when the FIFO is neither empty nor full.
- Arbitration (one write slot per cycle):
  - force = !empty && (starve_cnt == STARVE_MAX).
  - a_ready = !force.
  - A wins when a_valid && a_ready. B pops when !empty and A does not win.
  - starve_cnt increments when !empty and A wins, resets to 0 on any pop, and holds otherwise. It never exceeds STARVE_MAX.
- Write stage (1-cycle latency):
  - If a source wins in cycle N, then in cycle N+1: rf_we=1, rf_waddr=addr, rf_wdata=data.
  - If no source wins, rf_we=0 and rf_waddr/rf_wdata hold their values.
  - A winner with addr 0 is consumed with rf_we=0.
- Pending clear:
  - pend[rf_waddr] clears at the end of N+1, which is the same edge at which the register file writes.
  - From cycle N+2, hazard is 0 and the register file read returns the new data.
- Simultaneous set and clear of the same register on the same edge: set wins, because a new producer is in flight.
- Writeback to a register that is not pending is still written. Its scoreboard bit is unchanged.

Optional Feature:
RF_BYPASS_EN
- Defined:
  - Adds outputs fwd1 (1), fwd2 (1) and fwd_data (32).
  - Pending clears at the end of cycle N, when the source is accepted, not at N+1.
  - In cycle N+1: fwdN = rf_we && (rf_waddr == raddrN) && (raddrN != 0), and fwd_data = rf_wdata.
  - Decode muxes fwd_data, so the RAW stall is one cycle shorter.
- Undefined: none of these ports exist, and pending clears at the end of N+1 as specified above.

Test Plan:
- Reset check: assert resetn=0 mid-write -> rf_we=0, hazard1=0, b_ready=1, and issue_ready=1 for every dest.
- RAW hazard: issue r5; A writes r5=0xDEADBEEF in cycle 10 -> hazard1 (raddr1=5) stays 1 through cycle 11; rf_we=1 with waddr=5 in cycle 11; hazard1=0 in cycle 12. With RF_BYPASS_EN: hazard1=0 and fwd1=1 in cycle 11.
- WAW stall: issue r7 twice -> second issue_ready=0 until r7's writeback clears. Issue r0 -> issue_ready=1 and no pending bit is set.
- FIFO full: hold a_valid=1, push 4 B entries (r1..r4) -> b_ready=0 after the 4th push. After 3 A wins, a_ready=0 and B pops r1; pops repeat every 4th cycle in order r1..r4.
- Set/clear collision: issue r9 on the same edge r9's writeback clears -> pend[9] remains 1 and hazard stays 1.
- r0 write: A writes addr 0 data 0x1234 -> a_ready=1, rf_we=0 in the next cycle, and the scoreboard is unchanged.
